tile_sequencer: RTL and testbench

TILE_SEQUENCER -- requirements
Module: tile_sequencer

---
 rtl/tile_sequencer_if.sv | 28 ++
 rtl/tile_sequencer.sv | 144 ++++++++++++++
 tb/tb_tile_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/tile_sequencer_if.sv
// rtl/tile_sequencer_if.sv - job handshake and array control bundle for tile_sequencer
interface tile_sequencer_if;
    logic       start_valid;
    logic       start_ready;
    logic [7:0] num_tiles;
    logic       abort;
    logic       feed_en;
    logic [5:0] diag_idx;
    logic [7:0] tile_idx;
    logic       acc_clear;
    logic       acc_en;
    logic       busy;
    logic       result_valid;
    logic       result_ready;
    logic       err;

    modport master (
        output start_valid, num_tiles, abort, result_ready,
        input  start_ready, feed_en, diag_idx, tile_idx, acc_clear, acc_en,
               busy, result_valid, err
    );

    modport slave (
        input  start_valid, num_tiles, abort, result_ready,
        output start_ready, feed_en, diag_idx, tile_idx, acc_clear, acc_en,
               busy, result_valid, err
    );
endinterface

// File: rtl/tile_sequencer.sv
// rtl/tile_sequencer.sv - sequences clear/feed/gap/drain/output phases of a systolic array job
module tile_sequencer #(
    parameter int N        = 32,
    parameter int PIPE_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    tile_sequencer_if.slave  sif
);

    localparam int DIAG_LAST = 2 * N - 2;
    localparam int DRAIN_CYC = N + PIPE_LAT;
    localparam int DRW       = $clog2(DRAIN_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_GAP   = 3'd3,
        S_DRAIN = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    state_t         state_q, state_n;
    logic [5:0]     diag_q, diag_n;
    logic [7:0]     tile_q, tile_n;
    logic [7:0]     t_q, t_n;
    logic [DRW-1:0] drain_q, drain_n;
    logic           err_q, err_n;

    logic feed_en_q, acc_en_q, acc_clear_q, result_valid_q, start_ready_q, busy_q;
    logic more_tiles;

    assign more_tiles = ({1'b0, tile_q} + 9'd1) < {1'b0, t_q};

    always_comb begin
        state_n = state_q;
        diag_n  = '0;
        tile_n  = tile_q;
        t_n     = t_q;
        drain_n = '0;
        err_n   = 1'b0;

        case (state_q)
            S_IDLE: begin
                tile_n = '0;
                if (sif.start_valid) begin
                    if (sif.num_tiles != 8'd0) begin
                        t_n     = sif.num_tiles;
                        state_n = S_CLEAR;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                tile_n  = '0;
                state_n = S_FEED;
            end
            S_FEED: begin
                if (diag_q == 6'(DIAG_LAST)) begin
                    state_n = more_tiles ? S_GAP : S_DRAIN;
                end else begin
                    diag_n = diag_q + 6'd1;
                end
            end
            S_GAP: begin
                tile_n  = tile_q + 8'd1;
                state_n = S_FEED;
            end
            S_DRAIN: begin
                if (drain_q == DRW'(DRAIN_CYC - 1)) begin
                    state_n = S_OUT;
                end else begin
                    drain_n = drain_q + DRW'(1);
                end
            end
            S_OUT: begin
                if (sif.result_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // abort overrides everything, including a start or zero-tile reject in IDLE
        if (sif.abort) begin
            state_n = S_IDLE;
            diag_n  = '0;
            tile_n  = '0;
            t_n     = '0;
            drain_n = '0;
            err_n   = 1'b0;
        end

        if (state_n == S_IDLE) begin
            tile_n = '0;
        end
    end

    // Outputs are registered from the next state so they line up with state_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            diag_q         <= '0;
            tile_q         <= '0;
            t_q            <= '0;
            drain_q        <= '0;
            err_q          <= 1'b0;
            feed_en_q      <= 1'b0;
            acc_en_q       <= 1'b0;
            acc_clear_q    <= 1'b0;
            result_valid_q <= 1'b0;
            start_ready_q  <= 1'b1;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_n;
            diag_q         <= diag_n;
            tile_q         <= tile_n;
            t_q            <= t_n;
            drain_q        <= drain_n;
            err_q          <= err_n;
            feed_en_q      <= (state_n == S_FEED);
            acc_en_q       <= (state_n == S_FEED) || (state_n == S_GAP) || (state_n == S_DRAIN);
            acc_clear_q    <= (state_n == S_CLEAR);
            result_valid_q <= (state_n == S_OUT);
            start_ready_q  <= (state_n == S_IDLE);
            busy_q         <= (state_n != S_IDLE);
        end
    end

    assign sif.start_ready  = start_ready_q;
    assign sif.busy         = busy_q;
    assign sif.feed_en      = feed_en_q;
    assign sif.diag_idx     = diag_q;
    assign sif.tile_idx     = tile_q;
    assign sif.acc_clear    = acc_clear_q;
    assign sif.acc_en       = acc_en_q;
    assign sif.result_valid = result_valid_q;
    assign sif.err          = err_q;

endmodule

// File: tb/tb_tile_sequencer.sv
// tb/tb_tile_sequencer.sv - directed table-driven bench for tile_sequencer (N=32, PIPE_LAT=2)
module tb_tile_sequencer;

    localparam int FEED_LEN = 63;
    localparam int BUDGET   = 20000;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    tile_sequencer_if sif();

    tile_sequencer #(.N(32), .PIPE_LAT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int tiles;
        int first_rv;
        int feed_cnt;
        int acc_cnt;
        int last_acc;
        int hold;
    } job_t;

    job_t jobs[6];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input job_t j);
        int cyc, feed_cnt, acc_cnt, clr_cnt, first_feed, first_rv, last_acc;
        int falls, diag_bad, tile_bad, adj_bad, hold_bad;
        logic pf;
        logic [5:0] pd;
        sif.start_valid = 1'b1;
        sif.num_tiles   = 8'(j.tiles);
        step();
        sif.start_valid = 1'b0;
        if (j.tiles == 0) begin
            chk("zero_err", int'(sif.err), 1);
            chk("zero_ready", int'(sif.start_ready), 1);
            chk("zero_busy", int'(sif.busy), 0);
            chk("zero_clear", int'(sif.acc_clear), 0);
            step();
            chk("zero_err_one_cycle", int'(sif.err), 0);
            return;
        end
        cyc = 1; feed_cnt = 0; acc_cnt = 0; clr_cnt = 0; first_feed = 0; first_rv = 0;
        last_acc = 0; falls = 0; diag_bad = 0; tile_bad = 0; adj_bad = 0; hold_bad = 0;
        pf = 1'b0; pd = '0;
        chk("clear_at_cycle1", int'(sif.acc_clear), 1);
        while (first_rv == 0 && cyc < BUDGET) begin
            if (sif.acc_clear) clr_cnt++;
            if (sif.acc_en) begin
                acc_cnt++;
                last_acc = cyc;
            end
            if (sif.feed_en) begin
                if (first_feed == 0) first_feed = cyc;
                if (int'(sif.diag_idx) != feed_cnt % FEED_LEN) diag_bad++;
                if (int'(sif.tile_idx) != feed_cnt / FEED_LEN) tile_bad++;
                feed_cnt++;
            end else if (sif.diag_idx != 6'd0) begin
                diag_bad++;
            end
            if (pf && pd == 6'd62 && sif.feed_en) adj_bad++;
            if (pf && !sif.feed_en && sif.acc_en) falls++;
            pf = sif.feed_en;
            pd = sif.diag_idx;
            if (sif.result_valid) begin
                first_rv = cyc;
            end else begin
                step();
                cyc++;
            end
        end
        chk("rv_first_cycle", first_rv, j.first_rv);
        chk("clear_count", clr_cnt, 1);
        chk("first_feed_cycle", first_feed, 2);
        chk("feed_count", feed_cnt, j.feed_cnt);
        chk("acc_count", acc_cnt, j.acc_cnt);
        chk("last_acc_cycle", last_acc, j.last_acc);
        chk("feed_falls", falls, j.tiles);
        chk("diag_errors", diag_bad, 0);
        chk("tile_errors", tile_bad, 0);
        chk("no_back_to_back_tiles", adj_bad, 0);
        chk("tile_in_out", int'(sif.tile_idx), j.tiles - 1);
        chk("out_acc_en", int'(sif.acc_en), 0);
        for (int i = 0; i < j.hold; i++) begin
            if (!sif.result_valid || !sif.busy) hold_bad++;
            step();
        end
        if (!sif.result_valid) hold_bad++;
        chk("rv_held", hold_bad, 0);
        sif.result_ready = 1'b1;
        step();
        sif.result_ready = 1'b0;
        chk("after_rv", int'(sif.result_valid), 0);
        chk("after_ready", int'(sif.start_ready), 1);
        chk("after_tile", int'(sif.tile_idx), 0);
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        jobs[0] = '{tiles: 1,   first_rv: 99,    feed_cnt: 63,    acc_cnt: 97,    last_acc: 98,    hold: 0};
        jobs[1] = '{tiles: 2,   first_rv: 163,   feed_cnt: 126,   acc_cnt: 161,   last_acc: 162,   hold: 3};
        jobs[2] = '{tiles: 0,   first_rv: 0,     feed_cnt: 0,     acc_cnt: 0,     last_acc: 0,     hold: 0};
        jobs[3] = '{tiles: 1,   first_rv: 99,    feed_cnt: 63,    acc_cnt: 97,    last_acc: 98,    hold: 10};
        jobs[4] = '{tiles: 3,   first_rv: 227,   feed_cnt: 189,   acc_cnt: 225,   last_acc: 226,   hold: 0};
        jobs[5] = '{tiles: 255, first_rv: 16355, feed_cnt: 16065, acc_cnt: 16353, last_acc: 16354, hold: 1};

        rst_n = 1'b0;
        sif.start_valid  = 1'b0;
        sif.num_tiles    = 8'd0;
        sif.abort        = 1'b0;
        sif.result_ready = 1'b0;
        #23;
        chk("rst_start_ready", int'(sif.start_ready), 1);
        chk("rst_busy", int'(sif.busy), 0);
        chk("rst_feed_en", int'(sif.feed_en), 0);
        chk("rst_acc_en", int'(sif.acc_en), 0);
        chk("rst_rv", int'(sif.result_valid), 0);
        chk("rst_err", int'(sif.err), 0);
        step();
        rst_n = 1'b1;
        step();

        // result_ready outside OUT must be ignored
        sif.result_ready = 1'b1;
        for (int k = 0; k < 6; k++) run_job(jobs[k]);
        sif.result_ready = 1'b0;

        // abort in the middle of FEED
        sif.start_valid = 1'b1;
        sif.num_tiles   = 8'd2;
        step();
        sif.start_valid = 1'b0;
        n = 0;
        while (!(sif.feed_en && sif.diag_idx == 6'd20) && n < 200) begin
            step();
            n++;
        end
        chk("abort_reached_diag20", int'(n < 200), 1);
        sif.abort = 1'b1;
        step();
        sif.abort = 1'b0;
        chk("abort_busy", int'(sif.busy), 0);
        chk("abort_feed_en", int'(sif.feed_en), 0);
        chk("abort_diag", int'(sif.diag_idx), 0);
        chk("abort_acc_en", int'(sif.acc_en), 0);
        chk("abort_tile", int'(sif.tile_idx), 0);
        chk("abort_ready", int'(sif.start_ready), 1);

        // abort together with start in IDLE rejects the job, no err either
        sif.start_valid = 1'b1;
        sif.num_tiles   = 8'd5;
        sif.abort       = 1'b1;
        step();
        chk("abort_start_busy", int'(sif.busy), 0);
        chk("abort_start_clear", int'(sif.acc_clear), 0);
        sif.num_tiles = 8'd0;
        step();
        chk("abort_zero_err", int'(sif.err), 0);
        sif.start_valid = 1'b0;
        sif.abort       = 1'b0;
        step();
        chk("abort_idle_busy", int'(sif.busy), 0);

        // reset during DRAIN, then a fresh job with unchanged timing
        sif.start_valid = 1'b1;
        sif.num_tiles   = 8'd1;
        step();
        sif.start_valid = 1'b0;
        for (int k = 1; k < 70; k++) step();
        chk("drain_acc_en", int'(sif.acc_en), 1);
        chk("drain_feed_en", int'(sif.feed_en), 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", int'(sif.start_ready), 1);
        chk("rst_mid_busy", int'(sif.busy), 0);
        chk("rst_mid_acc_en", int'(sif.acc_en), 0);
        step();
        rst_n = 1'b1;
        run_job(jobs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
